num_digits: RTL and testbench

NUM_DIGITS -- requirements
Module: num_digits

---
 rtl/num_digits_if.sv | 27 ++
 rtl/num_digits.sv | 143 ++++++++++++++
 tb/tb_num_digits.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/num_digits_if.sv
// Bundle of the conversion handshake and the pixel-column display port
// of num_digits. The master drives requests and scan position; the slave
// returns status and glyph selection.
interface num_digits_if #(
  parameter int VAL_W = 17
);
  logic             start;
  logic [VAL_W-1:0] value;
  logic             busy;
  logic             done;
  logic [2:0]       ndigits;
  logic [9:0]       base_x;
  logic [9:0]       x;
  logic [3:0]       char;
  logic [9:0]       posx;
  logic             cell_valid;

  modport master (
    output start, value, base_x, x,
    input  busy, done, ndigits, char, posx, cell_valid
  );

  modport slave (
    input  start, value, base_x, x,
    output busy, done, ndigits, char, posx, cell_valid
  );
endinterface

// File: rtl/num_digits.sv
// Binary-to-BCD converter (shift-and-add-3) feeding a glyph cell locator.
// A captured value is converted over VAL_W cycles, then latched into a
// display register; the display side picks the digit and cell origin for
// the pixel column one ahead of x so its registered outputs line up with x.
module num_digits #(
  parameter int VAL_W  = 17,
  parameter int DIGITS = 6,
  parameter int CHAR_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  num_digits_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + VAL_W;
  localparam int CNT_W = $clog2(VAL_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  logic [1:0]       state;
  logic [SR_W-1:0]  sr;        // {BCD accumulator, binary remainder}
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] disp;      // digit 0 is the least significant nibble
  logic [2:0]       nd;
  logic             done_q;
  logic [3:0]       char_q;
  logic [9:0]       posx_q;
  logic             valid_q;

  logic [SR_W-1:0]  sr_next;
  logic [2:0]       nd_next;
  logic             hit;
  logic [3:0]       hit_char;
  logic [9:0]       hit_posx;

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    logic [SR_W-1:0] adj;
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[VAL_W + 4*i +: 4] >= 4'd5)
        adj[VAL_W + 4*i +: 4] = adj[VAL_W + 4*i +: 4] + 4'd3;
    end
    sr_next = {adj[SR_W-2:0], 1'b0};
  end

  // Significant digit count of the finished accumulator; zero shows one digit.
  always_comb begin
    nd_next = 3'd1;
    for (int i = 1; i < DIGITS; i++) begin
      if (sr[VAL_W + 4*i +: 4] != 4'd0)
        nd_next = 3'(i + 1);
    end
  end

  // Locate the cell containing the lookahead column x+1, at 16-bit width so
  // cell bounds beyond column 1023 never wrap back onto low columns.
  always_comb begin
    logic [15:0] col;
    logic [15:0] k;
    logic [15:0] cell_lo;
    hit      = 1'b0;
    hit_char = 4'd0;
    hit_posx = 10'd0;
    col      = 16'(bus.x) + 16'd1;
    for (int j = 0; j < DIGITS; j++) begin
      k       = 16'(nd) - 16'(j) - 16'd1;
      cell_lo = 16'(bus.base_x) + k * 16'(CHAR_W);
      if (3'(j) < nd && col < 16'd1024 && col >= cell_lo &&
          col < cell_lo + 16'(CHAR_W)) begin
        hit      = 1'b1;
        hit_char = disp[4*j +: 4];
        hit_posx = cell_lo[9:0];
      end
    end
  end

  // Conversion FSM: capture, VAL_W shift steps, then publish the result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state  <= S_IDLE;
      sr     <= '0;
      cnt    <= '0;
      disp   <= '0;
      nd     <= 3'd1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sr    <= {{BCD_W{1'b0}}, bus.value};
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr <= sr_next;
          if (cnt == CNT_W'(VAL_W - 1)) begin
            state <= S_LATCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LATCH: begin
          disp   <= sr[SR_W-1 -: BCD_W];
          nd     <= nd_next;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered glyph outputs; char and posx hold outside every cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_q  <= 4'd0;
      posx_q  <= 10'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= hit;
      if (hit) begin
        char_q <= hit_char;
        posx_q <= hit_posx;
      end
    end
  end

  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = done_q;
  assign bus.ndigits    = nd;
  assign bus.char       = char_q;
  assign bus.posx       = posx_q;
  assign bus.cell_valid = valid_q;
endmodule

// File: tb/tb_num_digits.sv
// Self-checking bench for num_digits: conversion latency and handshake,
// digit counts, glyph lookup over column sweeps, and reset mid-conversion,
// against a decimal arithmetic reference model.
module tb_num_digits;
  localparam int VAL_W  = 17;
  localparam int DIGITS = 6;
  localparam int CHAR_W = 16;

  logic clk = 1'b0;
  logic rst;

  num_digits_if #(.VAL_W(VAL_W)) bus ();

  num_digits #(.VAL_W(VAL_W), .DIGITS(DIGITS), .CHAR_W(CHAR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: the value the display should show and held glyph outputs.
  int cur_val  = 0;
  int cur_base = 0;
  int exp_char = 0;
  int exp_posx = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  function automatic int num_dig(input int v);
    int n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  // Present x = c-1 so the registered outputs after the edge describe column c.
  task automatic show_col(input int c);
    @(negedge clk);
    bus.x = 10'(c - 1);
    @(posedge clk);
    #1;
  endtask

  // Sweep columns lo..hi and compare against the decimal model.
  task automatic sweep(input int lo, input int hi);
    int nd;
    int k;
    int exp_valid;
    nd = num_dig(cur_val);
    for (int c = lo; c <= hi; c++) begin
      show_col(c);
      exp_valid = 0;
      if (c < 1024 && c >= cur_base) begin
        k = (c - cur_base) / CHAR_W;
        if (k < nd) begin
          exp_valid = 1;
          exp_char  = (cur_val / pow10(nd - 1 - k)) % 10;
          exp_posx  = cur_base + k * CHAR_W;
        end
      end
      check($sformatf("valid@%0d", c), int'(bus.cell_valid), exp_valid);
      check($sformatf("char@%0d", c), int'(bus.char), exp_char);
      check($sformatf("posx@%0d", c), int'(bus.posx), exp_posx);
    end
  endtask

  // Run one conversion; optionally re-pulse start mid-conversion with value 5.
  task automatic convert(input int val, input bit poke);
    int edges;
    int busy_cnt;
    bit got;
    show_col(1024);
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = VAL_W'(val);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_cnt  = int'(bus.busy);
    edges     = 0;
    got       = 1'b0;
    while (edges < 40 && !got) begin
      @(posedge clk);
      #1;
      edges++;
      if (poke && edges == 5) begin
        bus.start = 1'b1;
        bus.value = VAL_W'(5);
      end else if (poke && edges == 6) begin
        bus.start = 1'b0;
      end
      if (bus.done) got = 1'b1;
      else busy_cnt += int'(bus.busy);
    end
    check($sformatf("done_seen(%0d)", val), int'(got), 1);
    check($sformatf("latency(%0d)", val), edges, VAL_W + 1);
    check($sformatf("busy_cycles(%0d)", val), busy_cnt, VAL_W + 1);
    check($sformatf("busy_at_done(%0d)", val), int'(bus.busy), 0);
    check($sformatf("ndigits(%0d)", val), int'(bus.ndigits), num_dig(val));
    cur_val = val;
    @(posedge clk);
    #1;
    check($sformatf("done_pulse(%0d)", val), int'(bus.done), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_ndigits"}, int'(bus.ndigits), 1);
    check({tag, "_char"}, int'(bus.char), 0);
    check({tag, "_posx"}, int'(bus.posx), 0);
    check({tag, "_valid"}, int'(bus.cell_valid), 0);
  endtask

  initial begin
    int done_cnt;
    int v;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.value  = '0;
    bus.base_x = 10'd0;
    bus.x      = 10'd1023;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Zero converts to a single "0" digit.
    convert(0, 1'b0);
    check("ndigits_zero", int'(bus.ndigits), 1);
    cur_base = 0;
    bus.base_x = 10'(cur_base);
    sweep(1, 20);

    // 2048 at base 100: four cells spanning 100..163.
    convert(2048, 1'b0);
    check("ndigits_2048", int'(bus.ndigits), 4);
    cur_base = 100;
    bus.base_x = 10'(cur_base);
    sweep(1, 201);
    show_col(116);
    check("col116_char", int'(bus.char), 0);
    check("col116_posx", int'(bus.posx), 116);
    show_col(150);
    check("col150_char", int'(bus.char), 8);
    check("col150_posx", int'(bus.posx), 148);
    show_col(164);
    check("col164_valid", int'(bus.cell_valid), 0);
    exp_char = 8;
    exp_posx = 148;

    // Full-scale value; a start pulse while busy must be ignored.
    convert(131071, 1'b1);
    check("ndigits_131071", int'(bus.ndigits), 6);
    sweep(98, 200);

    // Reset during SHIFT cycle 8 abandons the conversion.
    show_col(1024);
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = VAL_W'(4321);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("busy_before_rst", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    cur_val  = 0;
    exp_char = 0;
    exp_posx = 0;
    done_cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      done_cnt += int'(bus.done);
    end
    check("no_done_after_rst", done_cnt, 0);
    convert(777, 1'b0);
    sweep(95, 160);

    // Field near the right edge: only 1000..1023 valid, no wrap to low x.
    convert(131071, 1'b0);
    cur_base = 1000;
    bus.base_x = 10'(cur_base);
    sweep(990, 1024);
    sweep(1, 120);

    // Random values at random positions.
    for (int t = 0; t < 6; t++) begin
      v = int'($urandom_range(0, 131071));
      convert(v, 1'b0);
      cur_base = int'($urandom_range(0, 1000));
      bus.base_x = 10'(cur_base);
      sweep((cur_base > 2) ? cur_base - 2 : 1,
            (cur_base + 100 > 1024) ? 1024 : cur_base + 100);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
